piso_serializer: RTL and testbench



---
 rtl/piso_serializer_if.sv | 27 ++
 rtl/piso_serializer.sv | 131 +++++++++++++
 tb/tb_piso_serializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_serializer_if                                                    |
// | Load handshake and serial stream bundle for piso_serializer.          |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, ser_out, ser_valid, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, ser_out, ser_valid, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_serializer                                                       |
// | Parallel-in serial-out shifter with valid/ready load and done pulse.  |
// | Optional trailing even-parity bit when PISO_PARITY_EN is defined.     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  piso_serializer_if.slave bus
);
  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
`endif

  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_shreg,     w_shreg_nxt;
  logic [CW-1:0]    r_cnt,       w_cnt_nxt;
  logic             r_ser_out,   w_ser_out_nxt;
  logic             r_ser_valid, w_ser_valid_nxt;
  logic             r_done,      w_done_nxt;
  logic             w_accept;
`ifdef PISO_PARITY_EN
  logic             r_parity,    w_parity_nxt;
`endif

  always_comb begin
    w_accept    = bus.load_valid && (r_state == S_IDLE);
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = bus.load_data;
          w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
          w_parity_nxt = ^bus.load_data;
`endif
        end
      end
      S_SHIFT: begin
        w_shreg_nxt = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};
        w_cnt_nxt   = r_cnt + CW'(1);
        if (r_cnt == c_last) begin
          w_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
`endif
`ifdef PISO_PARITY_EN
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are computed from next state so they can be registered directly.
    w_ser_valid_nxt = (w_state_nxt != S_IDLE);
    w_ser_out_nxt   = 1'b0;
    if (w_state_nxt == S_SHIFT) begin
      w_ser_out_nxt = MSB_FIRST ? w_shreg_nxt[WIDTH-1] : w_shreg_nxt[0];
    end
`ifdef PISO_PARITY_EN
    else if (w_state_nxt == S_PARITY) begin
      w_ser_out_nxt = w_parity_nxt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_done      <= w_done_nxt;
`ifdef PISO_PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.ser_out    = r_ser_out;
  assign bus.ser_valid  = r_ser_valid;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Bench for piso_serializer: MSB-first and LSB-first instances driven in
// lockstep, every cycle compared against a bit-stream model of the word.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int PLEN = W + 1;
`else
  localparam int PLEN = W;
`endif
  // {ready_m, ready_l, valid_m, valid_l, out_m, out_l, done_m, done_l}
  localparam logic [7:0] c_idle = 8'b11_00_00_00;
  localparam logic [7:0] c_done = 8'b11_00_00_11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic [7:0]   obs;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.load_valid = load_valid;
  assign bus_m.load_data  = load_data;
  assign bus_l.load_valid = load_valid;
  assign bus_l.load_data  = load_data;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bus(bus_m)
  );
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bus(bus_l)
  );

  assign obs = {bus_m.load_ready, bus_l.load_ready, bus_m.ser_valid, bus_l.ser_valid,
                bus_m.ser_out, bus_l.ser_out, bus_m.done, bus_l.done};

  // Bit i of the serial stream for word w; index W is the even-parity bit.
  function automatic logic exp_bit(logic [W-1:0] w, int i, bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  function automatic logic [7:0] busy_vec(logic [W-1:0] w, int i);
    return {2'b00, 2'b11, exp_bit(w, i, 1'b1), exp_bit(w, i, 1'b0), 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present w, expect acceptance on the next edge, then check every payload
  // cycle and the done cycle; load_data is scrambled while the word drains.
  task automatic drive_word(input logic [W-1:0] w, input bit hold, input string tag);
    load_valid = 1'b1;
    load_data  = w;
    total++;
    if (obs[7:6] !== 2'b11) begin
      bad++;
      $display("FAIL %s_ready got=%b exp=11", tag, obs[7:6]);
    end
    step();
    if (!hold) load_valid = 1'b0;
    for (int i = 0; i < PLEN; i++) begin
      total++;
      if (obs !== busy_vec(w, i)) begin
        bad++;
        $display("FAIL %s_bit%0d word=%h got=%b exp=%b", tag, i, w, obs, busy_vec(w, i));
      end
      load_data = W'($urandom);
      step();
    end
    total++;
    if (obs !== c_done) begin
      bad++;
      $display("FAIL %s_done word=%h got=%b exp=%b", tag, w, obs, c_done);
    end
  endtask

  task automatic idle_check(input string tag);
    load_valid = 1'b0;
    step();
    total++;
    if (obs !== c_idle) begin
      bad++;
      $display("FAIL %s_idle got=%b exp=%b", tag, obs, c_idle);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== c_idle) begin
        bad++;
        $display("FAIL reset_hold%0d got=%b exp=%b", i, obs, c_idle);
      end
    end
    reset = 1'b0;
    drive_word(8'hFF, 1'b0, "reset_first");
    idle_check("reset_first");
  endtask

  task automatic test_msb_first();
    drive_word(8'hA5, 1'b0, "a5");
    idle_check("a5");
  endtask

  task automatic test_lsb_first();
    drive_word(8'h01, 1'b0, "w01");
    idle_check("w01");
    drive_word(8'h07, 1'b0, "w07");
    idle_check("w07");
  endtask

  task automatic test_back_to_back();
    drive_word(8'hFF, 1'b1, "b2b_ff");
    drive_word(8'h00, 1'b1, "b2b_00");
    idle_check("b2b");
  endtask

  task automatic test_reset_mid();
    load_valid = 1'b1;
    load_data  = 8'hC3;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== busy_vec(8'hC3, i)) begin
        bad++;
        $display("FAIL mid_bit%0d got=%b exp=%b", i, obs, busy_vec(8'hC3, i));
      end
      if (i == 2) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    total++;
    if (obs !== c_idle) begin
      bad++;
      $display("FAIL mid_after_reset got=%b exp=%b", obs, c_idle);
    end
    idle_check("mid_no_done");
    drive_word(8'h3C, 1'b0, "mid_3c");
    idle_check("mid_3c");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] w;
      bit           hold;
      w    = W'($urandom);
      hold = 1'($urandom_range(0, 1));
      drive_word(w, hold, "rand");
      if (!hold) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_check("rand_gap");
      end
    end
    idle_check("rand_end");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
